imem_loader: RTL

Program loader that fills the instruction memory before the core runs. It accepts a byte stream over a valid/ready handshake and packs the bytes little-endian into 32-bit words. It issues one write per word at byte-addressed locations (PC-style, word index ×4) and holds the core in reset until the image is complete. It is the write side of the instruction memory; the core's fetch path is the read side.

---
 rtl/imem_loader.sv | 117 +++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader packing little-endian words into instruction memory
// Holds the core in reset until a full image of len_words words has been written.
module imem_loader #(
  parameter int DEPTH = 64,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len_words,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             we,
  output logic [31:0]      waddr,
  output logic [31:0]      wdata,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             cpu_rst
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

  localparam logic [31:0] DEPTH_U = DEPTH;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_word_idx;
  logic [LEN_W-1:0] w_idx_inc;
  logic [1:0]       r_byte_cnt;
  logic [23:0]      r_buf;
  logic [31:0]      r_waddr;
  logic [31:0]      r_wdata;
  logic             r_err;
  logic             w_len_ok;
  logic             w_start_seen;
  logic             w_xfer;
  logic             w_last_byte;
  logic             w_last_word;

  assign w_len_ok     = (len_words != '0) && (32'(len_words) <= DEPTH_U);
  assign w_start_seen = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_xfer       = byte_valid && (r_state == S_LOAD);
  assign w_last_byte  = (r_byte_cnt == 2'd3);
  assign w_idx_inc    = r_word_idx + 1'b1;
  assign w_last_word  = (w_idx_inc == r_len);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) w_state_nxt = w_len_ok ? S_LOAD : S_IDLE;
      end
      S_LOAD: begin
        if (w_xfer && w_last_byte) w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        w_state_nxt = w_last_word ? S_DONE : S_LOAD;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len      <= '0;
      r_word_idx <= '0;
      r_byte_cnt <= '0;
      r_buf      <= '0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_start_seen) begin
        if (w_len_ok) begin
          r_len      <= len_words;
          r_word_idx <= '0;
          r_byte_cnt <= '0;
          r_err      <= 1'b0;
        end else begin
          r_err <= 1'b1;
        end
      end
      if (w_xfer) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        case (r_byte_cnt)
          2'd0: r_buf[7:0]   <= byte_data;
          2'd1: r_buf[15:8]  <= byte_data;
          2'd2: r_buf[23:16] <= byte_data;
          default: begin
            // Word and address latch as the 4th byte lands so they are valid during WRITE.
            r_wdata <= {byte_data, r_buf};
            r_waddr <= 32'(r_word_idx) << 2;
          end
        endcase
      end
      if (r_state == S_WRITE) r_word_idx <= w_idx_inc;
    end
  end

  assign byte_ready = (r_state == S_LOAD);
  assign we         = (r_state == S_WRITE);
  assign busy       = (r_state == S_LOAD) || (r_state == S_WRITE);
  assign done       = (r_state == S_DONE);
  assign cpu_rst    = (r_state != S_DONE);
  assign waddr      = r_waddr;
  assign wdata      = r_wdata;
  assign err        = r_err;

endmodule
